// File: rtl/sdram_responder_if.sv
// sdram_responder_if
//   Command/address bus between an SDRAM host controller (master) and the
//   device-side responder (slave). The bidirectional DQ bus stays a plain
//   inout port on the responder so that it resolves as an ordinary net.
//   Signals:
//     addr            row / column / mode address bus
//     bank_addr       bank select
//     clock_enable    CKE; low turns the cycle into a NOP
//     cs_n, ras_n, cas_n, we_n  command pins
//     data_mask_low, data_mask_high  write byte masks, 1 masks the byte
interface sdram_responder_if #(
    parameter int unsigned ROW_WIDTH  = 13,
    parameter int unsigned BANK_WIDTH = 2
);
    logic [ROW_WIDTH-1:0]  addr;
    logic [BANK_WIDTH-1:0] bank_addr;
    logic                  clock_enable;
    logic                  cs_n;
    logic                  ras_n;
    logic                  cas_n;
    logic                  we_n;
    logic                  data_mask_low;
    logic                  data_mask_high;

    modport master (
        output addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
               data_mask_low, data_mask_high
    );

    modport slave (
        input  addr, bank_addr, clock_enable, cs_n, ras_n, cas_n, we_n,
               data_mask_low, data_mask_high
    );
endinterface

// File: rtl/sdram_responder.sv
// sdram_responder
//   Device-side SDRAM model: decodes the command bus, tracks the init
//   sequence, mode register (CAS latency) and per-bank open rows, and serves
//   single-word READ/WRITE from a small internal memory.
//   Ports:
//     clk, rst      single clock, asynchronous active-high reset
//     bus           command/address bus (sdram_responder_if.slave)
//     data          16-bit DQ, driven only during read data slots
//     init_done     init sequence (PALL, REF, REF, MRS) complete
//     cas_latency   current CL (2 or 3)
//     ref_count     wrapping count of REF commands
//     err_protocol  sticky protocol error
//     err_timing    sticky tRCD violation
//   Build option: define SDRAM_RESP_CHECK_EN to include the protocol and
//   tRCD checkers; otherwise both error outputs are tied low.
module sdram_responder #(
    parameter int unsigned ROW_WIDTH      = 13,
    parameter int unsigned COL_WIDTH      = 9,
    parameter int unsigned BANK_WIDTH     = 2,
    parameter int unsigned MEM_ADDR_WIDTH = 8,
    parameter int unsigned T_RCD          = 2
) (
    input  logic              clk,
    input  logic              rst,
    sdram_responder_if.slave  bus,
    inout  wire  [15:0]       data,
    output logic              init_done,
    output logic [1:0]        cas_latency,
    output logic [15:0]       ref_count,
    output logic              err_protocol,
    output logic              err_timing
);
    localparam int unsigned NUM_BANKS = 1 << BANK_WIDTH;
    localparam int unsigned MEM_WORDS = 1 << MEM_ADDR_WIDTH;

    typedef logic [MEM_ADDR_WIDTH-1:0] mem_idx_t;
    typedef enum logic [2:0] {WAIT_PALL, WAIT_REF1, WAIT_REF2, WAIT_MRS, READY} init_state_t;
    typedef enum logic [2:0] {CMD_NOP, CMD_ACT, CMD_READ, CMD_WRITE, CMD_PRE, CMD_REF,
                              CMD_MRS, CMD_BST} cmd_t;

    init_state_t                          state_q, state_d;
    logic [1:0]                           cl_q, cl_d;
    logic [15:0]                          ref_q, ref_d;
    logic [NUM_BANKS-1:0]                 open_q, open_d;
    logic [NUM_BANKS-1:0][ROW_WIDTH-1:0]  row_q, row_d;
    logic                                 s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
    mem_idx_t                             s1_idx_q, s1_idx_d, s2_idx_q, s2_idx_d;
    logic                                 out_vld_q, out_vld_d;
    logic [15:0]                          out_data_q, out_data_d;
    logic [15:0]                          mem [0:MEM_WORDS-1];

    cmd_t                 cmd;
    logic                 ready, mrs_valid, do_write;
    logic [ROW_WIDTH-1:0] acc_row;
    mem_idx_t             idx;

    always_comb begin
        cmd = CMD_NOP;
        if (bus.clock_enable && !bus.cs_n) begin
            case ({bus.ras_n, bus.cas_n, bus.we_n})
                3'b011:  cmd = CMD_ACT;
                3'b101:  cmd = CMD_READ;
                3'b100:  cmd = CMD_WRITE;
                3'b010:  cmd = CMD_PRE;
                3'b001:  cmd = CMD_REF;
                3'b000:  cmd = CMD_MRS;
                3'b110:  cmd = CMD_BST;
                default: cmd = CMD_NOP;
            endcase
        end
    end

    assign ready     = (state_q == READY);
    assign mrs_valid = ((bus.addr[6:4] == 3'b010) || (bus.addr[6:4] == 3'b011))
                       && (bus.addr[2:0] == 3'b000);
    // A closed bank is still accessed, through row 0.
    assign acc_row   = open_q[bus.bank_addr] ? row_q[bus.bank_addr] : '0;
    assign idx       = mem_idx_t'({bus.bank_addr, acc_row, bus.addr[COL_WIDTH-1:0]});
    assign do_write  = (cmd == CMD_WRITE) && ready;

    always_comb begin
        state_d  = state_q;
        cl_d     = cl_q;
        ref_d    = ref_q;
        open_d   = open_q;
        row_d    = row_q;
        // Read pipeline shifts every edge, independent of clock_enable.
        // CL=3 enters at stage 1, CL=2 at stage 2; the output register is
        // the final stage and fetches the word from memory.
        s1_vld_d   = 1'b0;
        s1_idx_d   = s1_idx_q;
        s2_vld_d   = s1_vld_q;
        s2_idx_d   = s1_idx_q;
        out_vld_d  = s2_vld_q;
        out_data_d = s2_vld_q ? mem[s2_idx_q] : out_data_q;

        case (cmd)
            CMD_ACT: begin
                if (ready) begin
                    open_d[bus.bank_addr] = 1'b1;
                    row_d[bus.bank_addr]  = bus.addr;
                end
            end
            CMD_READ: begin
                if (ready) begin
                    if (cl_q == 2'd2) begin
                        s2_vld_d = 1'b1;
                        s2_idx_d = idx;
                    end else begin
                        s1_vld_d = 1'b1;
                        s1_idx_d = idx;
                    end
                    if (bus.addr[10]) open_d[bus.bank_addr] = 1'b0;
                end
            end
            CMD_WRITE: begin
                if (ready && bus.addr[10]) open_d[bus.bank_addr] = 1'b0;
            end
            CMD_PRE: begin
                if (bus.addr[10]) begin
                    open_d = '0;
                    if (state_q == WAIT_PALL) state_d = WAIT_REF1;
                end else begin
                    open_d[bus.bank_addr] = 1'b0;
                end
            end
            CMD_REF: begin
                ref_d = ref_q + 16'd1;
                if (state_q == WAIT_REF1) state_d = WAIT_REF2;
                if (state_q == WAIT_REF2) state_d = WAIT_MRS;
            end
            CMD_MRS: begin
                if (mrs_valid) begin
                    cl_d = bus.addr[5:4];
                    if (state_q == WAIT_MRS) state_d = READY;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WAIT_PALL;
            cl_q       <= 2'd3;
            ref_q      <= '0;
            open_q     <= '0;
            row_q      <= '0;
            s1_vld_q   <= 1'b0;
            s1_idx_q   <= '0;
            s2_vld_q   <= 1'b0;
            s2_idx_q   <= '0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cl_q       <= cl_d;
            ref_q      <= ref_d;
            open_q     <= open_d;
            row_q      <= row_d;
            s1_vld_q   <= s1_vld_d;
            s1_idx_q   <= s1_idx_d;
            s2_vld_q   <= s2_vld_d;
            s2_idx_q   <= s2_idx_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage has no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (do_write) begin
            if (!bus.data_mask_low)  mem[idx][7:0]  <= data[7:0];
            if (!bus.data_mask_high) mem[idx][15:8] <= data[15:8];
        end
    end

    assign data        = out_vld_q ? out_data_q : 'z;
    assign init_done   = ready;
    assign cas_latency = cl_q;
    assign ref_count   = ref_q;

`ifdef SDRAM_RESP_CHECK_EN
    localparam int unsigned RCD_W = $clog2(T_RCD + 1);

    // Per-bank count of edges since ACT, saturating at T_RCD.
    logic [NUM_BANKS-1:0][RCD_W-1:0] rcd_q, rcd_d;
    logic                            err_p_q, err_p_d, err_t_q, err_t_d;

    always_comb begin
        err_p_d = err_p_q;
        err_t_d = err_t_q;
        for (int unsigned i = 0; i < NUM_BANKS; i++) begin
            rcd_d[i] = (rcd_q[i] < RCD_W'(T_RCD)) ? rcd_q[i] + RCD_W'(1) : rcd_q[i];
        end
        case (cmd)
            CMD_BST: err_p_d = 1'b1;
            CMD_ACT: begin
                if (!ready) begin
                    err_p_d = 1'b1;
                end else begin
                    if (open_q[bus.bank_addr]) err_p_d = 1'b1;
                    rcd_d[bus.bank_addr] = RCD_W'(1);
                end
            end
            CMD_READ, CMD_WRITE: begin
                if (!ready) begin
                    err_p_d = 1'b1;
                end else begin
                    if (!open_q[bus.bank_addr]) err_p_d = 1'b1;
                    else if (rcd_q[bus.bank_addr] < RCD_W'(T_RCD)) err_t_d = 1'b1;
                    if ((cmd == CMD_WRITE) && out_vld_q) err_p_d = 1'b1;
                end
            end
            CMD_REF: if (|open_q) err_p_d = 1'b1;
            CMD_MRS: if (!mrs_valid || (|open_q)) err_p_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcd_q   <= {NUM_BANKS{RCD_W'(T_RCD)}};
            err_p_q <= 1'b0;
            err_t_q <= 1'b0;
        end else begin
            rcd_q   <= rcd_d;
            err_p_q <= err_p_d;
            err_t_q <= err_t_d;
        end
    end

    assign err_protocol = err_p_q;
    assign err_timing   = err_t_q;
`else
    assign err_protocol = 1'b0;
    assign err_timing   = 1'b0;
`endif
endmodule
